// File: rtl/hyperbus_arbiter.sv
// rtl/hyperbus_arbiter.sv - two-port round-robin burst arbiter for the hyperbus leader controller
//
// Purpose: accepts burst commands from requesters A and B, grants one at a
// time (round-robin on contention) and drives the controller's hold-until-done
// rrq/wrq interface. Words are counted per burst; the request drops after the
// last word, done pulses as it drops, and GAP_CYCLES idle cycles follow.
// Optional feature macro: HBUS_ARB_TIMEOUT_EN (read watchdog, drives <p>_err).
//
// Ports (<p> = a/b):
//   clk, rstn                    clock, asynchronous active-low reset
//   <p>_cmd_*                    command request (valid/ready/we/reg/adr/len)
//   <p>_wdat/<p>_wmask/<p>_wready write word stream, consumed without back-pressure
//   <p>_rdat/<p>_rvalid          read word stream
//   <p>_done/<p>_err             end-of-burst pulse, watchdog abort pulse
//   hb_*                         controller-side request, address and data
module hyperbus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 16,
  parameter int MW         = 3,
  parameter int LEN_W      = 6,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a_cmd_valid,
  output logic             a_cmd_ready,
  input  logic             a_cmd_we,
  input  logic             a_cmd_reg,
  input  logic [AW-1:0]    a_cmd_adr,
  input  logic [LEN_W-1:0] a_cmd_len,
  input  logic [DW-1:0]    a_wdat,
  input  logic [MW-1:0]    a_wmask,
  output logic             a_wready,
  output logic [DW-1:0]    a_rdat,
  output logic             a_rvalid,
  output logic             a_done,
  output logic             a_err,
  input  logic             b_cmd_valid,
  output logic             b_cmd_ready,
  input  logic             b_cmd_we,
  input  logic             b_cmd_reg,
  input  logic [AW-1:0]    b_cmd_adr,
  input  logic [LEN_W-1:0] b_cmd_len,
  input  logic [DW-1:0]    b_wdat,
  input  logic [MW-1:0]    b_wmask,
  output logic             b_wready,
  output logic [DW-1:0]    b_rdat,
  output logic             b_rvalid,
  output logic             b_done,
  output logic             b_err,
  output logic [AW-1:0]    hb_adr_o,
  output logic             hb_reg_space_o,
  output logic [DW-1:0]    hb_dat_o,
  output logic [MW-1:0]    hb_mask_o,
  output logic             hb_wrq_o,
  output logic             hb_rrq_o,
  input  logic             hb_ready_i,
  input  logic             hb_valid_i,
  input  logic [DW-1:0]    hb_dat_i
);

  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  // Mask used for surplus controller write slots; MSB of the mask is never set.
  localparam logic [MW-1:0] TAIL_MASK = {1'b0, {(MW-1){1'b1}}};

  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;       // 0 = A owns the burst, 1 = B
  logic             rr_q, rr_d;         // 1 = B preferred on contention
  logic [GW-1:0]    gap_q, gap_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic             reg_q, reg_d;
  logic             wrq_q, wrq_d;
  logic             rrq_q, rrq_d;
  logic             tail_q, tail_d;     // write finished, controller may still take slots
  logic             a_done_q, a_done_d;
  logic             b_done_q, b_done_d;
  logic             grant_a, grant_b, wfire, rfire, finish;
`ifdef HBUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    wd_q, wd_d;
  logic             a_err_q, a_err_d;
  logic             b_err_q, b_err_d;
  logic             tmo;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    gap_d    = gap_q;
    left_d   = left_q;
    adr_d    = adr_q;
    reg_d    = reg_q;
    wrq_d    = wrq_q;
    rrq_d    = rrq_q;
    tail_d   = tail_q;
    a_done_d = 1'b0;
    b_done_d = 1'b0;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    wfire    = 1'b0;
    rfire    = 1'b0;
    finish   = 1'b0;
`ifdef HBUS_ARB_TIMEOUT_EN
    wd_d     = wd_q;
    a_err_d  = 1'b0;
    b_err_d  = 1'b0;
    tmo      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (a_cmd_valid || b_cmd_valid) begin
          grant_b = b_cmd_valid && (!a_cmd_valid || rr_q);
          grant_a = a_cmd_valid && !grant_b;
          sel_d   = grant_b;
          adr_d   = grant_b ? b_cmd_adr : a_cmd_adr;
          reg_d   = grant_b ? b_cmd_reg : a_cmd_reg;
          left_d  = grant_b ? b_cmd_len : a_cmd_len;
          if (left_d == '0) left_d = LEN_W'(1);
          tail_d  = 1'b0;
`ifdef HBUS_ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
          if (grant_b ? b_cmd_we : a_cmd_we) begin
            wrq_d   = 1'b1;
            state_d = ST_WRITE;
          end else begin
            rrq_d   = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (hb_ready_i && left_q != '0) begin
          wfire  = 1'b1;
          left_d = left_q - 1'b1;
          if (left_q == LEN_W'(1)) begin
            finish = 1'b1;
            tail_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (hb_valid_i && left_q != '0) begin
          rfire  = 1'b1;
          left_d = left_q - 1'b1;
          if (left_q == LEN_W'(1)) finish = 1'b1;
        end
`ifdef HBUS_ARB_TIMEOUT_EN
        if (hb_valid_i) begin
          wd_d = '0;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          finish = 1'b1;
          tmo    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d  = ST_IDLE;
      gap_d    = GW'(GAP_CYCLES);
      rr_d     = ~sel_q;
      wrq_d    = 1'b0;
      rrq_d    = 1'b0;
      a_done_d = ~sel_q;
      b_done_d = sel_q;
`ifdef HBUS_ARB_TIMEOUT_EN
      a_err_d  = tmo & ~sel_q;
      b_err_d  = tmo & sel_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      rr_q     <= 1'b0;
      gap_q    <= '0;
      left_q   <= '0;
      adr_q    <= '0;
      reg_q    <= 1'b0;
      wrq_q    <= 1'b0;
      rrq_q    <= 1'b0;
      tail_q   <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
`ifdef HBUS_ARB_TIMEOUT_EN
      wd_q     <= '0;
      a_err_q  <= 1'b0;
      b_err_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      gap_q    <= gap_d;
      left_q   <= left_d;
      adr_q    <= adr_d;
      reg_q    <= reg_d;
      wrq_q    <= wrq_d;
      rrq_q    <= rrq_d;
      tail_q   <= tail_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
`ifdef HBUS_ARB_TIMEOUT_EN
      wd_q     <= wd_d;
      a_err_q  <= a_err_d;
      b_err_q  <= b_err_d;
`endif
    end
  end

  // cmd_ready is combinational from cmd_valid, so hold it low while in reset.
  assign a_cmd_ready    = grant_a & rstn;
  assign b_cmd_ready    = grant_b & rstn;
  assign a_wready       = wfire & ~sel_q;
  assign b_wready       = wfire & sel_q;
  assign a_rvalid       = rfire & ~sel_q;
  assign b_rvalid       = rfire & sel_q;
  assign a_rdat         = a_rvalid ? hb_dat_i : '0;
  assign b_rdat         = b_rvalid ? hb_dat_i : '0;
  assign a_done         = a_done_q;
  assign b_done         = b_done_q;
  assign hb_adr_o       = adr_q;
  assign hb_reg_space_o = reg_q;
  assign hb_wrq_o       = wrq_q;
  assign hb_rrq_o       = rrq_q;
  assign hb_dat_o       = wfire ? (sel_q ? b_wdat : a_wdat) : '0;
  assign hb_mask_o      = wfire ? ((sel_q ? b_wmask : a_wmask) & TAIL_MASK)
                        : (tail_q && hb_ready_i) ? TAIL_MASK : '0;
`ifdef HBUS_ARB_TIMEOUT_EN
  assign a_err          = a_err_q;
  assign b_err          = b_err_q;
`else
  assign a_err          = 1'b0;
  assign b_err          = 1'b0;
`endif

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb/tb_hyperbus_arbiter.sv - self-checking bench for hyperbus_arbiter
module tb_hyperbus_arbiter;
  localparam int GAP = 2;
  localparam int TMO = 64;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        a_cmd_valid = 0, a_cmd_we = 0, a_cmd_reg = 0;
  logic [31:0] a_cmd_adr = 0;
  logic [5:0]  a_cmd_len = 0;
  logic [15:0] a_wdat = 0;
  logic [2:0]  a_wmask = 0;
  logic        b_cmd_valid = 0, b_cmd_we = 0, b_cmd_reg = 0;
  logic [31:0] b_cmd_adr = 0;
  logic [5:0]  b_cmd_len = 0;
  logic [15:0] b_wdat = 0;
  logic [2:0]  b_wmask = 0;
  logic        hb_ready_i = 0, hb_valid_i = 0;
  logic [15:0] hb_dat_i = 0;
  logic        a_cmd_ready, a_wready, a_rvalid, a_done, a_err;
  logic        b_cmd_ready, b_wready, b_rvalid, b_done, b_err;
  logic [15:0] a_rdat, b_rdat, hb_dat_o;
  logic [31:0] hb_adr_o;
  logic [2:0]  hb_mask_o;
  logic        hb_reg_space_o, hb_wrq_o, hb_rrq_o;

  hyperbus_arbiter #(.AW(32), .DW(16), .MW(3), .LEN_W(6), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready), .a_cmd_we(a_cmd_we), .a_cmd_reg(a_cmd_reg),
    .a_cmd_adr(a_cmd_adr), .a_cmd_len(a_cmd_len), .a_wdat(a_wdat), .a_wmask(a_wmask),
    .a_wready(a_wready), .a_rdat(a_rdat), .a_rvalid(a_rvalid), .a_done(a_done), .a_err(a_err),
    .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready), .b_cmd_we(b_cmd_we), .b_cmd_reg(b_cmd_reg),
    .b_cmd_adr(b_cmd_adr), .b_cmd_len(b_cmd_len), .b_wdat(b_wdat), .b_wmask(b_wmask),
    .b_wready(b_wready), .b_rdat(b_rdat), .b_rvalid(b_rvalid), .b_done(b_done), .b_err(b_err),
    .hb_adr_o(hb_adr_o), .hb_reg_space_o(hb_reg_space_o), .hb_dat_o(hb_dat_o), .hb_mask_o(hb_mask_o),
    .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o), .hb_ready_i(hb_ready_i), .hb_valid_i(hb_valid_i),
    .hb_dat_i(hb_dat_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {a_cmd_ready, a_wready, a_rdat, a_rvalid, a_done, a_err,
            b_cmd_ready, b_wready, b_rdat, b_rvalid, b_done, b_err,
            hb_adr_o, hb_reg_space_o, hb_dat_o, hb_mask_o, hb_wrq_o, hb_rrq_o};
  endfunction

  // Expected bursts in the order they must be granted.
  typedef struct {
    bit          port;
    bit          we;
    bit          rg;
    logic [31:0] adr;
    int          len;
    bit          tmo;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  bit   prev_req = 0, have_fall = 0;
  int   cnt = 0, fall_cyc = 0;

  // Burst-level model: every request window must match the next expected
  // burst, carry exactly max(len,1) words of the right kind for its owner,
  // end with done on that owner, and start no sooner than the gap allows.
  always @(negedge clk) begin
    bit req, pw, pr;
    if (!rstn) begin
      chk("reset_outputs_zero", all_outs(), 0);
      exp_q.delete();
      prev_req  = 0;
      have_fall = 0;
    end else begin
      req = hb_wrq_o | hb_rrq_o;
      chk("wrq_rrq_exclusive", hb_wrq_o & hb_rrq_o, 0);
      chk("mask_msb_zero", hb_mask_o[2], 0);
      if (a_rvalid) chk("a_rdat_fwd", a_rdat, hb_dat_i);
      if (b_rvalid) chk("b_rdat_fwd", b_rdat, hb_dat_i);
      if (a_wready) begin
        chk("a_wdat_fwd", hb_dat_o, a_wdat);
        chk("a_wmask_fwd", hb_mask_o, {1'b0, a_wmask[1:0]});
      end
      if (b_wready) begin
        chk("b_wdat_fwd", hb_dat_o, b_wdat);
        chk("b_wmask_fwd", hb_mask_o, {1'b0, b_wmask[1:0]});
      end
      if (req && !prev_req) begin
        chk("burst_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        cnt = 0;
        chk("rise_kind_we", hb_wrq_o, cur.we);
        chk("rise_reg", hb_reg_space_o, cur.rg);
        if (have_fall) chk("gap_respected", (cyc - fall_cyc) >= GAP + 1, 1);
      end
      if (req) begin
        chk("adr_stable", hb_adr_o, cur.adr);
        chk("reg_stable", hb_reg_space_o, cur.rg);
        pw = cur.port ? b_wready : a_wready;
        pr = cur.port ? b_rvalid : a_rvalid;
        chk("other_port_quiet", cur.port ? (a_wready | a_rvalid) : (b_wready | b_rvalid), 0);
        chk("wrong_word_kind", cur.we ? pr : pw, 0);
        cnt += int'(cur.we ? pw : pr);
      end else begin
        chk("no_words_when_idle", {a_wready, a_rvalid, b_wready, b_rvalid}, 0);
      end
      if (!req && prev_req) begin
        chk("burst_word_count", cnt, cur.tmo ? 0 : ((cur.len == 0) ? 1 : cur.len));
        chk("done_on_drop", {a_done, b_done}, cur.port ? 2'b01 : 2'b10);
        chk("err_on_drop", {a_err, b_err}, cur.tmo ? (cur.port ? 2'b01 : 2'b10) : 2'b00);
        fall_cyc  = cyc;
        have_fall = 1;
      end else begin
        chk("no_stray_done_err", {a_done, b_done, a_err, b_err}, 0);
      end
      prev_req = req;
    end
  end

  task automatic push(input bit p, input bit we, input bit rg, input logic [31:0] adr,
                      input int len, input bit tmo);
    exp_t e;
    e.port = p; e.we = we; e.rg = rg; e.adr = adr; e.len = len; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic set_cmd(input bit p, input bit v, input bit we, input bit rg,
                         input logic [31:0] adr, input logic [5:0] len);
    if (p) begin
      b_cmd_valid = v; b_cmd_we = we; b_cmd_reg = rg; b_cmd_adr = adr; b_cmd_len = len;
    end else begin
      a_cmd_valid = v; a_cmd_we = we; a_cmd_reg = rg; a_cmd_adr = adr; a_cmd_len = len;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the grant edge.
  task automatic issue(input bit p, input bit we, input bit rg, input logic [31:0] adr,
                       input logic [5:0] len, input bit tmo, output int rc);
    push(p, we, rg, adr, int'(len), tmo);
    set_cmd(p, 1, we, rg, adr, len);
    rc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p ? b_cmd_ready : a_cmd_ready) begin
        rc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("cmd_ready_seen", rc >= 0, 1);
    @(posedge clk); #1;
    set_cmd(p, 0, we, rg, adr, len);
  endtask

  task automatic rd_words(input int n, input logic [15:0] base, output int got);
    got = 0;
    for (int i = 0; i < n; i++) begin
      hb_valid_i = 1;
      hb_dat_i   = base + 16'(i);
      @(negedge clk);
      got += int'(a_rvalid) + int'(b_rvalid);
      @(posedge clk); #1;
    end
    hb_valid_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int rc, rb, n;
    // Reset: outputs must be zero even with live controller and command inputs.
    a_cmd_valid = 1; hb_ready_i = 1; hb_valid_i = 1; hb_dat_i = 16'hFFFF;
    #3;
    chk("reset_state_t0", all_outs(), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state_held", all_outs(), 0);
    a_cmd_valid = 0; hb_ready_i = 0; hb_valid_i = 0; hb_dat_i = 0;
    rstn = 1;
    #1;

    // Contention with the pointer at A: A first, B after the gap.
    push(0, 0, 0, 32'h40, 2, 0);
    push(1, 1, 0, 32'h80, 1, 0);
    set_cmd(0, 1, 0, 0, 32'h40, 6'd2);
    set_cmd(1, 1, 1, 0, 32'h80, 6'd1);
    @(negedge clk);
    chk("t2_a_granted", {a_cmd_ready, b_cmd_ready}, 2'b10);
    @(posedge clk); #1;
    a_cmd_valid = 0;
    chk("t2_rrq_latency", hb_rrq_o, 1);
    chk("t2_adr", hb_adr_o, 32'h40);
    rd_words(2, 16'h1230, n);
    chk("t2_a_rvalid_count", n, 2);
    chk("t2_rrq_dropped", hb_rrq_o, 0);
    rb = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_cmd_ready) begin
        rb = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t2_b_ready_after_gap", rb - fall_cyc, GAP);
    @(posedge clk); #1;
    b_cmd_valid = 0;
    chk("t2_b_wrq_high", hb_wrq_o, 1);
    chk("t2_b_request_offset", cyc - fall_cyc, GAP + 1);
    b_wdat = 16'hBEEF; b_wmask = 3'b101; hb_ready_i = 1;
    @(negedge clk);
    chk("t2_b_wready", b_wready, 1);
    chk("t2_b_mask", hb_mask_o, 3'b001);
    chk("t2_b_dat", hb_dat_o, 16'hBEEF);
    @(posedge clk); #1;
    hb_ready_i = 0;
    chk("t2_b_done", {b_done, hb_wrq_o}, 2'b10);
    idle(4);

    // Write of 4 words from A.
    issue(0, 1, 0, 32'h100, 6'd4, 0, rc);
    chk("t1_wrq_latency", hb_wrq_o, 1);
    chk("t1_adr", hb_adr_o, 32'h100);
    hb_ready_i = 1; n = 0;
    for (int i = 0; i < 4; i++) begin
      a_wdat = 16'hA000 + 16'(i); a_wmask = 3'(i);
      @(negedge clk);
      n += int'(a_wready);
      @(posedge clk); #1;
    end
    hb_ready_i = 0;
    chk("t1_wready_count", n, 4);
    chk("t1_wrq_drop_done", {hb_wrq_o, a_done}, 2'b01);
    @(posedge clk); #1;
    chk("t1_done_single", a_done, 0);
    idle(4);

    // Write of 2 words with the controller ready for 3 slots.
    issue(0, 1, 0, 32'h200, 6'd2, 0, rc);
    hb_ready_i = 1; n = 0; a_wmask = 3'b110;
    for (int i = 0; i < 3; i++) begin
      a_wdat = 16'h5500 + 16'(i);
      @(negedge clk);
      n += int'(a_wready);
      if (i == 2) begin
        chk("t4_tail_mask", hb_mask_o, 3'b011);
        chk("t4_tail_dat", hb_dat_o, 16'h0);
        chk("t4_tail_no_wready", a_wready, 0);
      end
      @(posedge clk); #1;
    end
    hb_ready_i = 0;
    chk("t4_wready_total", n, 2);
    idle(4);

    // Read of 3 words, controller supplies a 4th.
    issue(0, 0, 0, 32'h300, 6'd3, 0, rc);
    rd_words(3, 16'hC000, n);
    chk("t3_rvalid_count", n, 3);
    chk("t3_rrq_low", {hb_rrq_o, a_done}, 2'b01);
    rd_words(1, 16'hC003, n);
    chk("t3_extra_ignored", n, 0);
    idle(4);

    // Register-space read with len 0 from B counts as one word.
    issue(1, 0, 1, 32'hDEADBEEF, 6'd0, 0, rc);
    chk("t5_reg_space", {hb_reg_space_o, hb_rrq_o}, 2'b11);
    chk("t5_adr", hb_adr_o, 32'hDEADBEEF);
    rd_words(1, 16'h7777, n);
    chk("t5_rvalid_count", n, 1);
    chk("t5_b_done", {b_done, hb_rrq_o}, 2'b10);
    idle(4);

`ifdef HBUS_ARB_TIMEOUT_EN
    // Read that never gets data: the watchdog ends it after TIMEOUT cycles.
    issue(1, 0, 0, 32'h600, 6'd2, 1, rc);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!hb_rrq_o) break;
      n++;
      @(posedge clk); #1;
    end
    chk("t6_rrq_high_cycles", n, TMO);
    chk("t6_done_err", {b_done, b_err}, 2'b11);
    @(posedge clk); #1;
    idle(4);
`endif

    // Reset in the middle of a write burst.
    issue(0, 1, 0, 32'h400, 6'd4, 0, rc);
    hb_ready_i = 1; a_wdat = 16'h1111; a_wmask = 3'b001;
    @(negedge clk);
    chk("t7_wready_before_reset", a_wready, 1);
    @(posedge clk); #1;
    rstn = 0;
    #1;
    chk("t7_outputs_zero_midreset", all_outs(), 0);
    @(posedge clk); #1;
    rstn = 1; hb_ready_i = 0;
    #1;

    // Arbiter must be usable again after the discarded burst.
    issue(0, 0, 0, 32'h500, 6'd1, 0, rc);
    rd_words(1, 16'h4242, n);
    chk("t8_post_reset_read", {n[1:0], a_done}, 3'b011);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
